fp_divide: RTL and testbench

// - IEEE-754 single-precision divider (Result = A / B), multi-cycle, one divide in flight.
// - Sequential restoring mantissa divider with a start/done handshake.
// - Sits beside the FP multiplier in the RISC-V FP execute unit; handles FDIV.S.
// - Subnormals are flushed to zero on input and output.

---
 rtl/fp_divide.sv | 190 +++++++++++++++++++
 tb/tb_fp_divide.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divide.sv
// IEEE-754 single-precision divider (A / B). It runs a restoring mantissa divide
// that yields one quotient bit per cycle, flushes subnormals to zero and keeps one divide in flight.
module fp_divide #(
  parameter int          ROUND_MODE = 0,
  parameter logic [31:0] CANON_NAN  = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] Result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_DIVIDE = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [25:0] rem_q, rem_d, quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic        sign_s;
  logic [7:0]  exp_a_s, exp_b_s;
  logic [23:0] mant_a_s, mant_b_s;
  logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic        special_hit_s;
  logic [31:0] special_val_s;

  assign sign_s   = a_q[31] ^ b_q[31];
  assign exp_a_s  = a_q[30:23];
  assign exp_b_s  = b_q[30:23];
  assign mant_a_s = {1'b1, a_q[22:0]};
  assign mant_b_s = {1'b1, b_q[22:0]};
  assign a_nan_s  = (exp_a_s == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan_s  = (exp_b_s == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf_s  = (exp_a_s == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf_s  = (exp_b_s == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_zero_s = (exp_a_s == 8'h00);
  assign b_zero_s = (exp_b_s == 8'h00);

  // Special-operand classification, first match wins
  always_comb begin
    special_hit_s = 1'b1;
    special_val_s = CANON_NAN;
    if (a_nan_s || b_nan_s) begin
      special_val_s = CANON_NAN;
    end else if ((a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      special_val_s = CANON_NAN;
    end else if (a_inf_s || b_zero_s) begin
      special_val_s = {sign_s, 8'hFF, 23'd0};
    end else if (a_zero_s || b_inf_s) begin
      special_val_s = {sign_s, 31'd0};
    end else begin
      special_hit_s = 1'b0;
      special_val_s = CANON_NAN;
    end
  end

  // A trial subtraction leaves rem < mantB < 2^24, so 25 bits of difference are exact
  logic        rem_ge_s;
  logic [24:0] rem_diff_s;
  assign rem_ge_s   = (rem_q >= {2'b00, mant_b_s});
  assign rem_diff_s = rem_q[24:0] - {1'b0, mant_b_s};

  logic               norm_s, guard_s, sticky_s, inc_s;
  logic [22:0]        man_raw_s;
  logic [23:0]        man_sum_s;
  logic signed [9:0]  exp_base_s, exp_rnd_s;
  logic [31:0]        round_val_s;

  assign norm_s     = quo_q[25];
  assign man_raw_s  = norm_s ? quo_q[24:2] : quo_q[23:1];
  assign guard_s    = norm_s ? quo_q[1] : quo_q[0];
  assign sticky_s   = (norm_s & quo_q[0]) | (rem_q != 26'd0);
  assign exp_base_s = $signed({2'b00, exp_a_s}) - $signed({2'b00, exp_b_s})
                      + (norm_s ? 10'sd127 : 10'sd126);
  assign inc_s      = (ROUND_MODE == 0) && guard_s && (sticky_s || man_raw_s[0]);
  assign man_sum_s  = {1'b0, man_raw_s} + {23'd0, inc_s};
  assign exp_rnd_s  = exp_base_s + $signed({9'd0, man_sum_s[23]});

  // Range check of the rounded quotient
  always_comb begin
    round_val_s = {sign_s, exp_rnd_s[7:0], man_sum_s[22:0]};
    if (exp_rnd_s >= 10'sd255) begin
      round_val_s = {sign_s, 8'hFF, 23'd0};
    end else if (exp_rnd_s <= 10'sd0) begin
      round_val_s = {sign_s, 31'd0};
    end else begin
      round_val_s = {sign_s, exp_rnd_s[7:0], man_sum_s[22:0]};
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_UNPACK: begin
        if (special_hit_s) begin
          result_d = special_val_s;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          rem_d   = {2'b00, mant_a_s};
          quo_d   = 26'd0;
          cnt_d   = 5'd25;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        rem_d = rem_ge_s ? {rem_diff_s, 1'b0} : {rem_q[24:0], 1'b0};
        quo_d = {quo_q[24:0], rem_ge_s};
        if (cnt_q == 5'd0) begin
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_ROUND: begin
        result_d = round_val_s;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 26'd0;
      quo_q    <= 26'd0;
      cnt_q    <= 5'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_fp_divide.sv
// Self-checking bench for fp_divide. Two instances cover both rounding modes;
// results are compared against an integer long-division reference model.
module tb_fp_divide;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;
  int          errors = 0;
  int          checks = 0;

  fp_divide #(.ROUND_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .A(A), .B(B),
    .busy(busy0), .done(done0), .Result(res0)
  );
  fp_divide #(.ROUND_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .A(A), .B(B),
    .busy(busy1), .done(done1), .Result(res1)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {special, result}
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b, input int rm);
    int ea, eb, e;
    longint ma, mb, num, q, frac;
    bit sgn, st, g, s, an, bn, ai, bi, az, bz;
    logic [31:0] r;
    sgn = a[31] ^ b[31];
    ea = {24'd0, a[30:23]};
    eb = {24'd0, b[30:23]};
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn) return {1'b1, 32'h7FC00000};
    if ((az && bz) || (ai && bi)) return {1'b1, 32'h7FC00000};
    if (ai || bz) return {1'b1, sgn, 8'hFF, 23'd0};
    if (az || bi) return {1'b1, sgn, 31'd0};
    ma  = {40'd0, 1'b1, a[22:0]};
    mb  = {40'd0, 1'b1, b[22:0]};
    num = ma * 64'sd33554432;
    q   = num / mb;
    st  = (num % mb) != 0;
    if (q >= 64'sd33554432) begin
      frac = (q / 4) % 8388608;
      g = ((q / 2) % 2) != 0;
      s = ((q % 2) != 0) || st;
      e = ea - eb + 127;
    end else begin
      frac = (q / 2) % 8388608;
      g = (q % 2) != 0;
      s = st;
      e = ea - eb + 126;
    end
    if (rm == 0 && g && (s || (frac % 2) != 0)) begin
      frac = frac + 1;
      if (frac == 64'sd8388608) begin
        frac = 0;
        e = e + 1;
      end
    end
    if (e >= 255) r = {sgn, 8'hFF, 23'd0};
    else if (e <= 0) r = {sgn, 31'd0};
    else r = {sgn, e[7:0], frac[22:0]};
    return {1'b0, r};
  endfunction

  // Drives one operation from a negedge; reports latency, results and post-done state
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [31:0] r0, output logic [31:0] r1,
                        output logic busy_c1, output logic tail_ok);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 0;
    r0 = 32'd0;
    r1 = 32'd0;
    busy_c1 = 1'b0;
    tail_ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) busy_c1 = busy0 & busy1;
      if (done0 && done1) begin
        lat = n;
        r0 = res0;
        r1 = res1;
        @(negedge clk);
        tail_ok = !done0 && !busy0 && !done1 && !busy1 && (res0 == r0) && (res1 == r1);
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy0, done0, res0, busy1, done1, res1} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b res=%h busy1=%b done1=%b res1=%h required all 0",
               busy0, done0, res0, busy1, done1, res1);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy0, done0);
    end
  endtask

  task automatic test_directed;
    logic [31:0] va[10]  = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                             32'h7F800000, 32'h7FC00001, 32'h7F000000, 32'h00800000, 32'h00000001};
    logic [31:0] vb[10]  = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h00000000,
                             32'h7F800000, 32'h3F800000, 32'h3E800000, 32'h40000000, 32'h3F800000};
    logic [31:0] ve0[10] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                             32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000};
    logic [31:0] ve1[10] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                             32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000};
    int          vl[10]  = '{29, 29, 2, 2, 2, 2, 2, 29, 29, 2};
    int lat;
    logic [31:0] r0, r1;
    logic bc1, tail;
    for (int i = 0; i < 10; i++) begin
      run_op(va[i], vb[i], lat, r0, r1, bc1, tail);
      checks++;
      if (r0 !== ve0[i]) begin
        errors++;
        $display("FAIL directed_rne[%0d]: %h/%h got %h required %h", i, va[i], vb[i], r0, ve0[i]);
      end
      checks++;
      if (r1 !== ve1[i]) begin
        errors++;
        $display("FAIL directed_trunc[%0d]: %h/%h got %h required %h", i, va[i], vb[i], r1, ve1[i]);
      end
      checks++;
      if (lat != vl[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d]: done in cycle %0d required %0d", i, lat, vl[i]);
      end
      checks++;
      if (bc1 !== 1'b1 || tail !== 1'b1) begin
        errors++;
        $display("FAIL directed_handshake[%0d]: busy_cycle1=%b single_pulse_and_idle=%b required 1 1",
                 i, bc1, tail);
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3: v[30:23] = 8'(250 + $urandom_range(0, 4));
      4: v[30:23] = 8'(1 + $urandom_range(0, 3));
      5: v[22:0] = 23'd0;
      default: v[30:23] = 8'(100 + $urandom_range(0, 55));
    endcase
    return v;
  endfunction

  task automatic test_random;
    int lat;
    logic [31:0] a, b, r0, r1;
    logic [32:0] m0, m1;
    logic bc1, tail;
    for (int i = 0; i < 60; i++) begin
      a = rand_operand();
      b = rand_operand();
      m0 = ref_div(a, b, 0);
      m1 = ref_div(a, b, 1);
      run_op(a, b, lat, r0, r1, bc1, tail);
      checks++;
      if (r0 !== m0[31:0] || r1 !== m1[31:0]) begin
        errors++;
        $display("FAIL random[%0d]: %h/%h got %h,%h required %h,%h", i, a, b, r0, r1, m0[31:0], m1[31:0]);
      end
      checks++;
      if (lat != (m0[32] ? 2 : 29) || !tail) begin
        errors++;
        $display("FAIL random_latency[%0d]: %h/%h done cycle %0d tail=%b required %0d 1",
                 i, a, b, lat, tail, m0[32] ? 2 : 29);
      end
    end
  endtask

  task automatic test_reset_abort;
    int lat, seen;
    logic [31:0] r0, r1;
    logic bc1, tail;
    run_op(32'h40C00000, 32'h40000000, lat, r0, r1, bc1, tail);
    A = 32'h3F800000;
    B = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || res0 !== 32'd0 || res1 !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b res=%h res1=%h required 0 0 0 0", busy0, done0, res0, res1);
    end
    #2;
    reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done0 || done1 || busy0) seen++;
    end
    checks++;
    if (seen != 0 || res0 !== 32'd0) begin
      errors++;
      $display("FAIL abort_no_done: activity cycles=%0d res=%h required 0 00000000", seen, res0);
    end
  endtask

  task automatic test_busy_ignore;
    int lat, extra;
    logic [31:0] r0;
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    extra = 0;
    r0 = 32'd0;
    for (int n = 1; n <= 70; n++) begin
      start = (n == 5 || n == 15 || n == 28) ? 1'b1 : 1'b0;
      A = 32'h3F800000;
      B = 32'h40400000;
      @(negedge clk);
      if (done0) begin
        if (lat == 0) begin
          lat = n;
          r0 = res0;
        end else begin
          extra++;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (lat != 29 || r0 !== 32'h40400000) begin
      errors++;
      $display("FAIL busy_ignore: done cycle %0d res %h required 29 40400000", lat, r0);
    end
    checks++;
    if (extra != 0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_extra: extra dones %0d busy %b required 0 0", extra, busy0);
    end
  endtask

  task automatic test_back_to_back;
    int d[3];
    logic [31:0] r0[3], r1[3];
    int k, drained;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = 0;
      r0[i] = 32'd0;
      r1[i] = 32'd0;
    end
    A = 32'h40C00000;
    B = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1;
    A = 32'h3F800000;
    B = 32'h40400000;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (done0 && k < 3) begin
        d[k] = n;
        r0[k] = res0;
        r1[k] = res1;
        k++;
      end
    end
    start = 1'b0;
    drained = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!busy0 && !busy1) begin
        drained = 1;
        break;
      end
    end
    checks++;
    if (d[0] != 29 || d[1] != 59) begin
      errors++;
      $display("FAIL b2b_timing: done cycles %0d,%0d required 29,59", d[0], d[1]);
    end
    checks++;
    if (r0[0] !== 32'h40400000 || r0[1] !== 32'h3EAAAAAB || r1[1] !== 32'h3EAAAAAA) begin
      errors++;
      $display("FAIL b2b_results: %h %h %h required 40400000 3EAAAAAB 3EAAAAAA", r0[0], r0[1], r1[1]);
    end
    checks++;
    if (drained != 1) begin
      errors++;
      $display("FAIL b2b_drain: busy still %b after bound, required 0", busy0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
